pico_mips_seq: RTL and testbench

- Parametrised multicycle accumulator core, the next generation of the picoMIPS datapath and control.
- Generalised data width, register-file depth and program depth; adds jumps, a zero-test branch, HALT, saturating add, and a two-way input handshake.
- Fetches from an external synchronous program ROM. Drives a registered output port (board LEDs). Sits under the board top, which ties the ROM, switches and LEDs.

---
 rtl/pico_mips_seq.sv | 169 ++++++++++++++++
 tb/tb_pico_mips_seq.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pico_mips_seq.sv
// Multicycle accumulator core: FETCH/DECODE/EXEC sequencing over an external synchronous ROM,
// with Q1.(DATA_W-1) fractional multiply, optional saturating add and a two-way input handshake.
module pico_mips_seq #(
  parameter int DATA_W  = 8,
  parameter int NREGS   = 4,
  parameter int PC_W    = 5,
  parameter int ADD_SAT = 0
) (
  input  logic                              Clock,
  input  logic                              Reset,
  output logic [PC_W-1:0]                   PCAddr,
  input  logic [3+$clog2(NREGS)+DATA_W:0]   Instr,
  input  logic signed [DATA_W-1:0]          InData,
  input  logic                              Handshake,
  output logic signed [DATA_W-1:0]          Out,
  output logic signed [DATA_W-1:0]          Acc,
  output logic                              Halted,
  output logic                              Waiting
);

  localparam int RA_W    = $clog2(NREGS);
  localparam int INSTR_W = 4 + RA_W + DATA_W;

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_WAIT   = 3'd3;
  localparam logic [2:0] S_HALT   = 3'd4;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LDI   = 4'h1;
  localparam logic [3:0] OP_LDR   = 4'h2;
  localparam logic [3:0] OP_STR   = 4'h3;
  localparam logic [3:0] OP_ADDI  = 4'h4;
  localparam logic [3:0] OP_ADDR  = 4'h5;
  localparam logic [3:0] OP_MULI  = 4'h6;
  localparam logic [3:0] OP_MULR  = 4'h7;
  localparam logic [3:0] OP_INW   = 4'h8;
  localparam logic [3:0] OP_WAITL = 4'h9;
  localparam logic [3:0] OP_OUT   = 4'hA;
  localparam logic [3:0] OP_JMP   = 4'hB;
  localparam logic [3:0] OP_JZ    = 4'hC;
  localparam logic [3:0] OP_HALT  = 4'hD;

  localparam logic signed [DATA_W-1:0] VAL_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] VAL_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic [2:0]                 state_q, state_d;
  logic [PC_W-1:0]            pc_q, pc_d, pc_inc;
  logic signed [DATA_W-1:0]   acc_q, acc_d;
  logic signed [DATA_W-1:0]   out_q, out_d;
  logic [INSTR_W-1:0]         ir_q, ir_d;
  logic signed [DATA_W-1:0]   regs_q [NREGS];
  logic signed [DATA_W-1:0]   regs_d [NREGS];

  logic [3:0]                 op;
  logic [RA_W-1:0]            ra;
  logic signed [DATA_W-1:0]   imm;
  logic signed [DATA_W-1:0]   rval;
  logic                       hs_ok;

  function automatic logic signed [DATA_W-1:0] add_fn(input logic signed [DATA_W-1:0] a,
                                                      input logic signed [DATA_W-1:0] b);
    logic signed [DATA_W:0] s;
    s = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    if (ADD_SAT != 0 && s[DATA_W] != s[DATA_W-1])
      add_fn = s[DATA_W] ? VAL_MIN : VAL_MAX;
    else
      add_fn = s[DATA_W-1:0];
  endfunction

  // Fractional multiply; MIN*MIN would be +1.0, which is unrepresentable, so clamp to MAX.
  function automatic logic signed [DATA_W-1:0] fmul_fn(input logic signed [DATA_W-1:0] a,
                                                       input logic signed [DATA_W-1:0] b);
    logic signed [2*DATA_W-1:0] p;
    p = a * b;
    if (a == VAL_MIN && b == VAL_MIN)
      fmul_fn = VAL_MAX;
    else
      fmul_fn = p[2*DATA_W-2:DATA_W-1];
  endfunction

  assign op     = ir_q[INSTR_W-1 -: 4];
  assign ra     = ir_q[DATA_W +: RA_W];
  assign imm    = ir_q[DATA_W-1:0];
  assign rval   = regs_q[ra];
  assign pc_inc = pc_q + PC_W'(1);
  // INW proceeds on Handshake high, WAITL on Handshake low.
  assign hs_ok  = (op == OP_INW) ? Handshake : !Handshake;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    acc_d   = acc_q;
    out_d   = out_q;
    ir_d    = ir_q;
    regs_d  = regs_q;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        ir_d    = Instr;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_inc;
        case (op)
          OP_LDI:  acc_d = imm;
          OP_LDR:  acc_d = rval;
          OP_STR:  regs_d[ra] = acc_q;
          OP_ADDI: acc_d = add_fn(acc_q, imm);
          OP_ADDR: acc_d = add_fn(acc_q, rval);
          OP_MULI: acc_d = fmul_fn(acc_q, imm);
          OP_MULR: acc_d = fmul_fn(acc_q, rval);
          OP_INW, OP_WAITL: begin
            if (hs_ok) begin
              if (op == OP_INW) acc_d = InData;
            end else begin
              state_d = S_WAIT;
              pc_d    = pc_q;
            end
          end
          OP_OUT:  out_d = acc_q;
          OP_JMP:  pc_d = PC_W'($unsigned(imm));
          OP_JZ:   if (acc_q == '0) pc_d = PC_W'($unsigned(imm));
          OP_HALT: begin
            state_d = S_HALT;
            pc_d    = pc_q;
          end
          default: ;
        endcase
      end
      S_WAIT: begin
        if (hs_ok) begin
          if (op == OP_INW) acc_d = InData;
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      ir_q    <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      ir_q    <= ir_d;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign PCAddr  = pc_q;
  assign Acc     = acc_q;
  assign Out     = out_q;
  assign Halted  = (state_q == S_HALT);
  assign Waiting = (state_q == S_WAIT);

endmodule

// File: tb/tb_pico_mips_seq.sv
// Directed bench for pico_mips_seq: two cores (wrapping and saturating add) fed from ROM models.
module tb_pico_mips_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  pc0, pc1;
  logic [13:0] instr0, instr1;
  logic [7:0]  indata;
  logic        hs;
  logic [7:0]  out0, out1, acc0, acc1;
  logic        halt0, halt1, wait0, wait1;

  logic [13:0] rom [32];
  int vectors = 0;
  int miscompares = 0;
  int cyc;
  int wcnt;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    instr0 <= rom[pc0];
    instr1 <= rom[pc1];
  end

  pico_mips_seq #(.DATA_W(8), .NREGS(4), .PC_W(5), .ADD_SAT(0)) dut0 (
    .Clock(clk), .Reset(rst), .PCAddr(pc0), .Instr(instr0), .InData(indata),
    .Handshake(hs), .Out(out0), .Acc(acc0), .Halted(halt0), .Waiting(wait0));

  pico_mips_seq #(.DATA_W(8), .NREGS(4), .PC_W(5), .ADD_SAT(1)) dut1 (
    .Clock(clk), .Reset(rst), .PCAddr(pc1), .Instr(instr1), .InData(indata),
    .Handshake(hs), .Out(out1), .Acc(acc1), .Halted(halt1), .Waiting(wait1));

  function automatic logic [13:0] ins(input logic [3:0] op, input logic [1:0] r, input logic [7:0] imm);
    return {op, r, imm};
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 32; i++) rom[i] = 14'h0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  task automatic run_halt(input int max, output int n);
    do_reset();
    n = 0;
    while (!(halt0 && halt1) && n < max) begin
      tick(1);
      n++;
    end
  endtask

  initial begin
    rst = 1'b1; hs = 1'b0; indata = 8'h00;
    clear_rom();
    tick(2);
    chk("rst_pc", {3'b0, pc0}, 8'h00);
    chk("rst_acc", acc0, 8'h00);
    chk("rst_out", out0, 8'h00);
    chk("rst_flags", {6'b0, halt0, wait0}, 8'h00);
    rst = 1'b0;

    // Fractional multiply 0.5*0.5 and CPI
    clear_rom();
    rom[0] = ins(4'h1, 2'd0, 8'h40);
    rom[1] = ins(4'h6, 2'd0, 8'h40);
    rom[2] = ins(4'hA, 2'd0, 8'h00);
    rom[3] = ins(4'hD, 2'd0, 8'h00);
    run_halt(100, cyc);
    chk("p1_cycles", cyc[7:0], 8'd12);
    chk("p1_out", out0, 8'h20);
    chk("p1_halted", {7'b0, halt0}, 8'h01);
    chk("p1_pc", {3'b0, pc0}, 8'h03);

    // MIN*MIN clamps, MIN*MAX
    clear_rom();
    rom[0] = ins(4'h1, 2'd0, 8'h80);
    rom[1] = ins(4'h6, 2'd0, 8'h80);
    rom[2] = ins(4'hA, 2'd0, 8'h00);
    rom[3] = ins(4'h1, 2'd0, 8'h80);
    rom[4] = ins(4'h6, 2'd0, 8'h7F);
    rom[5] = ins(4'hD, 2'd0, 8'h00);
    run_halt(100, cyc);
    chk("p2_minmin", out0, 8'h7F);
    chk("p2_minmax", acc0, 8'h81);

    // Wrapping vs saturating add
    clear_rom();
    rom[0] = ins(4'h1, 2'd0, 8'h70);
    rom[1] = ins(4'h4, 2'd0, 8'h20);
    rom[2] = ins(4'hA, 2'd0, 8'h00);
    rom[3] = ins(4'h1, 2'd0, 8'h90);
    rom[4] = ins(4'h4, 2'd0, 8'h90);
    rom[5] = ins(4'hD, 2'd0, 8'h00);
    run_halt(100, cyc);
    chk("p3_wrap_pos", out0, 8'h90);
    chk("p3_wrap_neg", acc0, 8'h20);
    chk("p3_sat_pos", out1, 8'h7F);
    chk("p3_sat_neg", acc1, 8'h80);

    // Register file, MULR/ADDR, reserved opcode
    clear_rom();
    rom[0]  = ins(4'h1, 2'd0, 8'h33);
    rom[1]  = ins(4'h3, 2'd3, 8'h00);
    rom[2]  = ins(4'h1, 2'd0, 8'h00);
    rom[3]  = ins(4'h2, 2'd3, 8'h00);
    rom[4]  = ins(4'hA, 2'd0, 8'h00);
    rom[5]  = ins(4'h1, 2'd0, 8'h40);
    rom[6]  = ins(4'h3, 2'd2, 8'h00);
    rom[7]  = ins(4'h1, 2'd0, 8'h40);
    rom[8]  = ins(4'h7, 2'd2, 8'h00);
    rom[9]  = ins(4'h5, 2'd3, 8'h00);
    rom[10] = ins(4'h5, 2'd1, 8'h00);
    rom[11] = ins(4'hE, 2'd1, 8'hFF);
    rom[12] = ins(4'hD, 2'd0, 8'h00);
    run_halt(100, cyc);
    chk("p5_str_ldr", out0, 8'h33);
    chk("p5_mulr_addr", acc0, 8'h53);
    chk("p5_pc", {3'b0, pc0}, 8'h0C);

    // Reset while halted, registers cleared
    clear_rom();
    rom[0] = ins(4'h2, 2'd3, 8'h00);
    rom[1] = ins(4'h5, 2'd2, 8'h00);
    rom[2] = ins(4'hA, 2'd0, 8'h00);
    rom[3] = ins(4'hD, 2'd0, 8'h00);
    rst = 1'b1;
    tick(1);
    chk("hrst_pc", {3'b0, pc0}, 8'h00);
    chk("hrst_out", out0, 8'h00);
    chk("hrst_acc", acc0, 8'h00);
    chk("hrst_halted", {7'b0, halt0}, 8'h00);
    run_halt(100, cyc);
    chk("hrst_regs", acc0, 8'h00);
    chk("hrst_restart_pc", {3'b0, pc0}, 8'h03);

    // JZ taken with wide target, PC wrap, JZ fall-through, JMP
    clear_rom();
    rom[0]  = ins(4'h2, 2'd0, 8'h00);
    rom[1]  = ins(4'hC, 2'd0, 8'h3E);
    rom[2]  = ins(4'hA, 2'd0, 8'h00);
    rom[3]  = ins(4'h1, 2'd0, 8'h01);
    rom[4]  = ins(4'hC, 2'd0, 8'h06);
    rom[5]  = ins(4'hB, 2'd0, 8'h08);
    rom[6]  = ins(4'h4, 2'd0, 8'h01);
    rom[7]  = ins(4'hD, 2'd0, 8'h00);
    rom[8]  = ins(4'h4, 2'd0, 8'h01);
    rom[9]  = ins(4'hD, 2'd0, 8'h00);
    rom[30] = ins(4'h1, 2'd0, 8'h0A);
    rom[31] = ins(4'h3, 2'd0, 8'h00);
    run_halt(200, cyc);
    chk("p4_cycles", cyc[7:0], 8'd36);
    chk("p4_out", out0, 8'h0A);
    chk("p4_acc", acc0, 8'h02);
    chk("p4_pc", {3'b0, pc0}, 8'h09);

    // Handshake: INW waits, WAITL waits, then both complete immediately
    clear_rom();
    rom[0] = ins(4'h8, 2'd0, 8'h00);
    rom[1] = ins(4'hA, 2'd0, 8'h00);
    rom[2] = ins(4'h9, 2'd0, 8'h00);
    rom[3] = ins(4'h8, 2'd0, 8'h00);
    rom[4] = ins(4'h9, 2'd0, 8'h00);
    rom[5] = ins(4'hD, 2'd0, 8'h00);
    hs = 1'b0; indata = 8'h11;
    do_reset();
    tick(3);
    chk("inw_wait_pc", {3'b0, pc0}, 8'h00);
    wcnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (wait0 && wait1) wcnt++;
      if (i == 9) begin
        indata = 8'h5A;
        hs = 1'b1;
      end
      tick(1);
    end
    chk("inw_wait_cycles", wcnt[7:0], 8'd10);
    chk("inw_acc", acc0, 8'h5A);
    chk("inw_done_wait", {7'b0, wait0}, 8'h00);
    chk("inw_done_pc", {3'b0, pc0}, 8'h01);
    tick(6);
    chk("hs_out", out0, 8'h5A);
    chk("waitl_wait", {7'b0, wait0}, 8'h01);
    chk("waitl_wait_pc", {3'b0, pc0}, 8'h02);
    hs = 1'b0;
    tick(1);
    chk("waitl_done", {7'b0, wait0}, 8'h00);
    chk("waitl_done_pc", {3'b0, pc0}, 8'h03);
    hs = 1'b1; indata = 8'h3C;
    tick(3);
    chk("inw_imm_acc", acc0, 8'h3C);
    chk("inw_imm_wait", {7'b0, wait0}, 8'h00);
    chk("inw_imm_pc", {3'b0, pc0}, 8'h04);
    hs = 1'b0;
    tick(3);
    chk("waitl_imm_wait", {7'b0, wait0}, 8'h00);
    chk("waitl_imm_pc", {3'b0, pc0}, 8'h05);
    tick(3);
    chk("hs_halted", {7'b0, halt0}, 8'h01);

    // Reset in the middle of WAIT
    clear_rom();
    rom[0] = ins(4'h1, 2'd0, 8'h66);
    rom[1] = ins(4'hA, 2'd0, 8'h00);
    rom[2] = ins(4'h8, 2'd0, 8'h00);
    hs = 1'b0;
    do_reset();
    tick(9);
    chk("wrst_pre_wait", {7'b0, wait0}, 8'h01);
    chk("wrst_pre_out", out0, 8'h66);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("wrst_pc", {3'b0, pc0}, 8'h00);
    chk("wrst_acc", acc0, 8'h00);
    chk("wrst_out", out0, 8'h00);
    chk("wrst_flags", {6'b0, halt0, wait0}, 8'h00);
    tick(3);
    chk("wrst_restart_acc", acc0, 8'h66);
    chk("wrst_restart_pc", {3'b0, pc0}, 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
